// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_pkg
// Description : Shared types and constants for the core's EX/MEM boundary:
//               memory-access FSM state enum, ALU op codes, bus byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Memory-access unit FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mau_state_e;

  // ALU operation codes produced by the decoder for EX
  localparam logic [4:0] ALU_ADD     = 5'b01101;
  localparam logic [4:0] ALU_LW_JALR = 5'b10100;
  localparam logic [4:0] ALU_SW      = 5'b10101;

  // Full-word byte enables on the data-memory bus
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_access_unit_if
// Description : Request/grant/response data-memory bus between the
//               memory-access stage (master) and data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM stage. Runs lw/sw over the data-memory bus, stalls the
//               core until the access completes (or times out / is found
//               misaligned) and drives register-file writeback for all
//               instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              reg_write_i,
  input  logic [4:0]        rd_i,
  input  logic [31:0]       ALUOut_i,
  input  logic [31:0]       StoreData_i,
  output logic              stall_o,
  mem_access_unit_if.master bus,
  output logic              wb_en_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:2]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic             misal_q, misal_d;
  logic             tout_q, tout_d;

  logic             w_mem_op;
  logic             w_expired;

  assign w_mem_op  = valid_i & (mem_read_i | mem_write_i);
  // Last permitted cycle of REQ+WAIT; a completion in this cycle still wins
  assign w_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state, latch and timeout-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    we_d    = we_q;
    misal_d = misal_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        if (w_mem_op) begin
          addr_d  = ALUOut_i[31:2];
          wdata_d = StoreData_i;
          rd_d    = rd_i;
          // lw+sw together is treated as a read
          we_d    = mem_write_i & ~mem_read_i;
          misal_d = |ALUOut_i[1:0];
          tout_d  = 1'b0;
          cnt_d   = '0;
          state_d = (|ALUOut_i[1:0]) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_gnt_i && bus.mem_rvalid_i) begin
          rdata_d = bus.mem_rdata_i;
          state_d = S_DONE;
        end else if (w_expired) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end else if (bus.mem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_rvalid_i) begin
          rdata_d = bus.mem_rdata_i;
          state_d = S_DONE;
        end else if (w_expired) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears FSM, counter and all latches immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      misal_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      misal_q <= misal_d;
      tout_q  <= tout_d;
    end
  end

  // Output decode; everything is held at 0 while reset is asserted
  always_comb begin
    stall_o         = 1'b0;
    wb_en_o         = 1'b0;
    wb_rd_o         = '0;
    wb_data_o       = '0;
    misalign_o      = 1'b0;
    bus_err_o       = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (rst) begin
      bus.mem_addr_o  = {addr_q, 2'b00};
      bus.mem_wdata_o = wdata_q;
      case (state_q)
        S_IDLE: begin
          if (w_mem_op) begin
            stall_o = 1'b1;
          end else if (valid_i) begin
            wb_en_o   = reg_write_i;
            wb_rd_o   = rd_i;
            wb_data_o = ALUOut_i;
          end
        end
        S_REQ: begin
          stall_o       = 1'b1;
          bus.mem_req_o = 1'b1;
          bus.mem_we_o  = we_q;
          bus.mem_be_o  = BE_WORD;
        end
        S_WAIT: begin
          stall_o = 1'b1;
        end
        default: begin
          misalign_o = misal_q;
          bus_err_o  = tout_q;
          if (!we_q && !misal_q && !tout_q) begin
            wb_en_o   = 1'b1;
            wb_rd_o   = rd_q;
            wb_data_o = rdata_q;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit: IDLE decode vector
//               table, directed multi-cycle sequences, randomized accesses
//               against a transaction-level latency/outcome model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_read_i, mem_write_i, reg_write_i;
  logic [4:0]  rd_i;
  logic [31:0] ALUOut_i, StoreData_i;
  logic        stall_o, wb_en_o, misalign_o, bus_err_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .reg_write_i (reg_write_i),
    .rd_i        (rd_i),
    .ALUOut_i    (ALUOut_i),
    .StoreData_i (StoreData_i),
    .stall_o     (stall_o),
    .bus         (bus_if),
    .wb_en_o     (wb_en_o),
    .wb_rd_o     (wb_rd_o),
    .wb_data_o   (wb_data_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

  typedef struct {
    logic        v, rd, wr, rw;
    logic [4:0]  rdi;
    logic [31:0] alu;
    logic        e_stall, e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic r, input logic w, input logic rw,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
    valid_i = v; mem_read_i = r; mem_write_i = w; reg_write_i = rw;
    rd_i = rd; ALUOut_i = alu; StoreData_i = sd;
  endtask

  // One instruction from presentation to completion. Memory grants g cycles
  // after the request starts and responds r cycles after the grant (r=0 means
  // same cycle). Expectations come from the timing rules, not the FSM.
  task automatic run_txn(input string tag, input logic r_op, input logic w_op, input logic rw,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdat, input int g, input int r);
    bit mem_op, is_st, mis, exp_err, exp_wb;
    int total_wait, exp_done, exp_req, limit;
    int done_k, req_n, mis_n, err_n, fld_err;
    logic done_en;
    logic [4:0] done_rd;
    logic [31:0] done_data;
    mem_op  = r_op | w_op;
    is_st   = w_op & ~r_op;
    mis     = mem_op && (addr[1:0] != 2'b00);
    exp_err = 1'b0;
    total_wait = (r == 0) ? g + 1 : g + 1 + r;
    if (!mem_op) begin
      exp_done = 0; exp_req = 0; limit = 3;
    end else if (mis) begin
      exp_done = 1; exp_req = 0; limit = 1 + g + r + 3;
    end else begin
      exp_err  = (total_wait > TO);
      exp_done = 1 + ((total_wait < TO) ? total_wait : TO);
      exp_req  = (g + 1 < TO) ? g + 1 : TO;
      limit    = ((exp_done > 1 + g + r) ? exp_done : 1 + g + r) + 3;
    end
    exp_wb = mem_op ? (!is_st && !mis && !exp_err) : rw;
    done_k = -1; req_n = 0; mis_n = 0; err_n = 0; fld_err = 0;
    done_en = 1'b0; done_rd = '0; done_data = '0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (done_k < 0) set_instr(1'b1, r_op, w_op, rw, rd, addr, sd);
      else            set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      bus_if.mem_gnt_i    = (k == 1 + g);
      bus_if.mem_rvalid_i = (k == 1 + g + r);
      bus_if.mem_rdata_i  = bus_if.mem_rvalid_i ? rdat : ~rdat;
      @(negedge clk);
      if (done_k < 0) begin
        if (stall_o) begin
          if (wb_en_o) fld_err++;
        end else begin
          done_k = k; done_en = wb_en_o; done_rd = wb_rd_o; done_data = wb_data_o;
        end
      end else if (wb_en_o) begin
        fld_err++;
      end
      if (bus_if.mem_req_o) begin
        req_n++;
        if (bus_if.mem_addr_o !== {addr[31:2], 2'b00} || bus_if.mem_wdata_o !== sd ||
            bus_if.mem_we_o !== is_st || bus_if.mem_be_o !== 4'hF) fld_err++;
      end
      mis_n += int'(misalign_o);
      err_n += int'(bus_err_o);
    end
    bus_if.mem_gnt_i = 1'b0; bus_if.mem_rvalid_i = 1'b0;
    chk({tag, "_done_cycle"}, done_k, exp_done);
    chk({tag, "_req_cycles"}, req_n, exp_req);
    chk({tag, "_wb_en"}, done_en, exp_wb);
    if (exp_wb || !mem_op) begin
      chk({tag, "_wb_rd"}, done_rd, rd);
      chk({tag, "_wb_data"}, done_data, mem_op ? rdat : addr);
    end
    chk({tag, "_misalign_pulses"}, mis_n, mis ? 1 : 0);
    chk({tag, "_bus_err_pulses"}, err_n, exp_err ? 1 : 0);
    chk({tag, "_bus_fields_bad"}, fld_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, g, r;
    logic [31:0] a;
    // IDLE decode vectors
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_002A, 1'b0, 1'b1, 5'd5, 32'h0000_002A};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_1234, 1'b0, 1'b0, 5'd9, 32'h0000_1234};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0055, 1'b0, 1'b0, 5'd0, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_0040, 1'b1, 1'b0, 5'd0, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0000_0044, 1'b1, 1'b0, 5'd0, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0043, 1'b1, 1'b0, 5'd0, 32'h0000_0000};

    // Reset state: outputs forced low even with a live instruction present
    rst = 1'b0;
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h2A, 32'h0);
    bus_if.mem_gnt_i = 1'b0; bus_if.mem_rvalid_i = 1'b0; bus_if.mem_rdata_i = '0;
    #3;
    chk("rst_stall", stall_o, 0);
    chk("rst_wb_en", wb_en_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_req", bus_if.mem_req_o, 0);
    chk("rst_addr", bus_if.mem_addr_o, 0);
    repeat (2) @(negedge clk);
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    rst = 1'b1;

    // Table-driven IDLE decode; memory ops are drained by a fast memory
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_instr(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].rdi, vecs[i].alu, 32'h0);
      @(negedge clk);
      chk("vec_stall", stall_o, vecs[i].e_stall);
      chk("vec_wb_en", wb_en_o, vecs[i].e_wb);
      if (!vecs[i].e_stall) begin
        chk("vec_wb_rd", wb_rd_o, vecs[i].e_rd);
        chk("vec_wb_data", wb_data_o, vecs[i].e_data);
      end
      chk("vec_req", bus_if.mem_req_o, 0);
      for (int d = 0; d < 3; d++) begin
        @(posedge clk); #1;
        valid_i = 1'b0; bus_if.mem_gnt_i = 1'b1; bus_if.mem_rvalid_i = 1'b1;
      end
      @(posedge clk); #1;
      bus_if.mem_gnt_i = 1'b0; bus_if.mem_rvalid_i = 1'b0;
    end

    // Directed multi-cycle cases
    run_txn("nonmem", 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_002A, 32'h0, 32'h0, 0, 0);
    run_txn("lw_zero_wait", 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1);
    run_txn("sw_gnt3", 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0200, 32'h1234_5678, 32'h0, 3, 1);
    run_txn("lw_misalign", 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0102, 32'h0, 32'h0, 0, 1);
    run_txn("lw_timeout", 1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0300, 32'h0, 32'hFFFF_FFFF, 30, 0);
    run_txn("lw_last_cycle", 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, 14, 1);
    run_txn("lw_gnt_rv_last", 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0308, 32'h0, 32'h0BAD_CAFE, 15, 0);
    run_txn("lw_gnt_late", 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_030C, 32'h0, 32'h1111_2222, 15, 1);
    run_txn("rw_both", 1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_0400, 32'h5555_AAAA, 32'h7777_8888, 1, 0);
    run_txn("x0_nonmem", 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0099, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset in REQ: request drops without a clock edge
    @(posedge clk); #1;
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0500, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rreq_pre_req", bus_if.mem_req_o, 1);
    #1 rst = 1'b0; valid_i = 1'b0;
    #1;
    chk("rreq_req", bus_if.mem_req_o, 0);
    chk("rreq_stall", stall_o, 0);
    @(negedge clk); rst = 1'b1;

    // Asynchronous reset in WAIT, then a stray response must be ignored
    @(posedge clk); #1;
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0600, 32'h0);
    @(posedge clk); #1;
    bus_if.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("rwait_pre_stall", stall_o, 1);
    #2 rst = 1'b0; valid_i = 1'b0;
    #1;
    chk("rwait_stall", stall_o, 0);
    chk("rwait_req", bus_if.mem_req_o, 0);
    chk("rwait_wb_en", wb_en_o, 0);
    chk("rwait_addr", bus_if.mem_addr_o, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'hAAAA_5555;
    @(negedge clk);
    chk("stray_wb_en0", wb_en_o, 0);
    @(posedge clk); #1;
    bus_if.mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("stray_wb_en1", wb_en_o, 0);
    chk("stray_stall", stall_o, 0);
    run_txn("post_rst", 1'b0, 1'b0, 1'b1, 5'd13, 32'h0000_0777, 32'h0, 32'h0, 0, 0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      g  = ($urandom_range(0, 7) == 0) ? 18 : int'($urandom_range(0, 4));
      r  = ($urandom_range(0, 7) == 0) ? 16 : int'($urandom_range(0, 3));
      run_txn("rnd", (op == 1) || (op == 3), (op == 2) || (op == 3), 1'($urandom_range(0, 1)),
              5'($urandom), a, $urandom, $urandom, g, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
